// File: rtl/volume_level_pwm.sv
// Saturating volume level with mute, driven by one-cycle inc/dec/mute pulses.
// The effective level is rendered as a PWM whose duty is latched only at period wrap.
module volume_level_pwm #(
    parameter int WIDTH    = 4,
    parameter int DEFAULT  = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             increment,
    input  logic             decrement,
    input  logic             mute_toggle,
    output logic [WIDTH-1:0] level,
    output logic             muted,
    output logic             at_max,
    output logic             at_min,
    output logic             changed,
    output logic             pwm_out
);

    localparam logic [WIDTH-1:0] MAX_LEVEL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_LAST   = MAX_LEVEL - WIDTH'(1);
    localparam int               PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] level_reg, level_next;
    logic             muted_reg, muted_next;
    logic             changed_reg;
    logic             pwm_reg;
    logic [PW-1:0]    presc_reg;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] duty_reg;
    logic [WIDTH-1:0] eff;
    logic             tick;
    logic             wrap;

    // Mute toggle wins outright; a simultaneous inc+dec cancels to nothing.
    always_comb begin
        level_next = level_reg;
        muted_next = muted_reg;
        if (mute_toggle) begin
            muted_next = ~muted_reg;
        end else if (increment && !decrement) begin
            muted_next = 1'b0;
            if (level_reg != MAX_LEVEL)
                level_next = level_reg + WIDTH'(1);
        end else if (decrement && !increment) begin
            muted_next = 1'b0;
            if (level_reg != '0)
                level_next = level_reg - WIDTH'(1);
        end
    end

    assign eff  = muted_reg ? '0 : level_reg;
    assign tick = (presc_reg == PRESC_LAST);
    assign wrap = tick && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            level_reg   <= WIDTH'(DEFAULT);
            muted_reg   <= 1'b0;
            changed_reg <= 1'b0;
            pwm_reg     <= 1'b0;
            presc_reg   <= '0;
            cnt_reg     <= '0;
            duty_reg    <= '0;
        end else begin
            level_reg   <= level_next;
            muted_reg   <= muted_next;
            changed_reg <= (level_next != level_reg) || (muted_next != muted_reg);
            presc_reg   <= tick ? '0 : presc_reg + PW'(1);
            if (tick)
                cnt_reg <= wrap ? '0 : cnt_reg + WIDTH'(1);
            // Duty only moves at the period boundary so a period is never cut short.
            if (wrap)
                duty_reg <= eff;
            pwm_reg     <= (cnt_reg < duty_reg);
        end
    end

    assign level   = level_reg;
    assign muted   = muted_reg;
    assign at_max  = (level_reg == MAX_LEVEL);
    assign at_min  = (level_reg == '0);
    assign changed = changed_reg;
    assign pwm_out = pwm_reg;

endmodule

// File: tb/tb_volume_level_pwm.sv
// Scoreboarded bench: stimulus queues expected {level,muted} per change, a monitor pops on changed.
module tb_volume_level_pwm;

    logic       clk = 1'b0;
    logic       n_reset, increment, decrement, mute_toggle;
    logic [3:0] level;
    logic       muted, at_max, at_min, changed, pwm_out;

    logic       n_reset2, increment2, decrement2, mute_toggle2;
    logic [3:0] level2;
    logic       muted2, at_max2, at_min2, changed2, pwm_out2;

    int tests = 0;
    int fails = 0;
    int changes_seen = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    volume_level_pwm #(.WIDTH(4), .DEFAULT(8), .PRESCALE(1)) dut (
        .clk(clk), .n_reset(n_reset), .increment(increment), .decrement(decrement),
        .mute_toggle(mute_toggle), .level(level), .muted(muted), .at_max(at_max),
        .at_min(at_min), .changed(changed), .pwm_out(pwm_out)
    );

    volume_level_pwm #(.WIDTH(4), .DEFAULT(8), .PRESCALE(3)) dut3 (
        .clk(clk), .n_reset(n_reset2), .increment(increment2), .decrement(decrement2),
        .mute_toggle(mute_toggle2), .level(level2), .muted(muted2), .at_max(at_max2),
        .at_min(at_min2), .changed(changed2), .pwm_out(pwm_out2)
    );

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end else begin
            $display("[TB] ok %s = %0d", name, actual);
        end
    endtask

    // Monitor: every changed pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (n_reset && changed) begin
            changes_seen++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL changed_unexpected: got level=%0d muted=%0d expected no change",
                         level, muted);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if ({level, muted} !== e) begin
                    fails++;
                    $display("FAIL changed_event: got level=%0d muted=%0d expected level=%0d muted=%0d",
                             level, muted, e[4:1], e[0]);
                end else begin
                    $display("[TB] event level=%0d muted=%0d", level, muted);
                end
            end
        end
    end

    // One-cycle pulse on the PRESCALE=1 instance with hand-computed result.
    task automatic step(input logic i, input logic d, input logic m,
                        input int exp_level, input logic exp_muted, input logic exp_chg);
        increment   = i;
        decrement   = d;
        mute_toggle = m;
        if (exp_chg)
            exp_q.push_back({4'(exp_level), exp_muted});
        @(posedge clk);
        #1;
        increment   = 1'b0;
        decrement   = 1'b0;
        mute_toggle = 1'b0;
        check("level", int'(level), exp_level);
        check("muted", int'(muted), int'(exp_muted));
    endtask

    task automatic count_high(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_out) cnt++;
        end
    endtask

    initial begin
        int hi;
        int base;
        int win1;
        int win2;

        n_reset = 1'b0; increment = 1'b0; decrement = 1'b0; mute_toggle = 1'b0;
        n_reset2 = 1'b1; increment2 = 1'b0; decrement2 = 1'b0; mute_toggle2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_reset = 1'b1;
        check("reset_level", int'(level), 8);
        check("reset_muted", int'(muted), 0);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_changed", int'(changed), 0);
        check("reset_at_max", int'(at_max), 0);
        check("reset_at_min", int'(at_min), 0);

        repeat (32) @(posedge clk);
        count_high(15, hi);
        check("pwm_duty8_high_in_15", hi, 8);

        // Saturating increments: only the first seven change anything.
        for (int k = 1; k <= 10; k++)
            step(1'b1, 1'b0, 1'b0, (8 + k > 15) ? 15 : 8 + k, 1'b0, k <= 7);
        check("at_max", int'(at_max), 1);
        repeat (32) @(posedge clk);
        count_high(30, hi);
        check("pwm_duty15_high_in_30", hi, 30);

        base = changes_seen;
        for (int k = 1; k <= 20; k++)
            step(1'b0, 1'b1, 1'b0, (15 - k < 0) ? 0 : 15 - k, 1'b0, k <= 15);
        @(negedge clk);
        check("dec_changed_pulses", changes_seen - base, 15);
        check("at_min", int'(at_min), 1);
        repeat (32) @(posedge clk);
        count_high(30, hi);
        check("pwm_duty0_high_in_30", hi, 0);

        for (int k = 1; k <= 8; k++)
            step(1'b1, 1'b0, 1'b0, k, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8, 1'b1, 1'b1);
        repeat (32) @(posedge clk);
        count_high(15, hi);
        check("pwm_muted_high_in_15", hi, 0);
        step(1'b1, 1'b0, 1'b0, 9, 1'b0, 1'b1);

        step(1'b1, 1'b1, 1'b0, 9, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 9, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 9, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        // PRESCALE=3 instance: after reset edge E0, pwm samples after E46..E90 are
        // period with duty 8, E91..E135 period with duty 3.
        @(posedge clk);
        #1;
        n_reset2 = 1'b0;
        @(posedge clk);
        #1;
        n_reset2 = 1'b1;
        win1 = 0;
        win2 = 0;
        for (int k = 1; k <= 141; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k >= 46 && k <= 90 && pwm_out2) win1++;
            if (k >= 91 && k <= 135 && pwm_out2) win2++;
            if (k == 50) decrement2 = 1'b1;
            if (k == 55) decrement2 = 1'b0;
            if (k == 60) check("p3_level_after_dec", int'(level2), 3);
            if (k == 140) begin
                check("p3_pwm_high_before_reset", int'(pwm_out2), 1);
                n_reset2 = 1'b0;
            end
            if (k == 141) begin
                check("p3_pwm_after_reset", int'(pwm_out2), 0);
                check("p3_level_after_reset", int'(level2), 8);
                n_reset2 = 1'b1;
            end
        end
        check("p3_period_duty8_high", win1, 24);
        check("p3_period_duty3_high", win2, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
